// File: rtl/idct_pkg.sv
// rtl/idct_pkg.sv - block modes, block lengths and helpers for the IDCT transpose buffer scheduler
package idct_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_4    = 2'b01;
  localparam logic [1:0] MODE_8    = 2'b10;

  localparam int BLK4_LEN = 16;
  localparam int BLK8_LEN = 64;

  function automatic logic [5:0] blk_last(input logic [1:0] mode);
    return (mode == MODE_4) ? 6'(BLK4_LEN - 1) : 6'(BLK8_LEN - 1);
  endfunction

  function automatic logic mode_legal(input logic [1:0] mode);
    return (mode == MODE_4) || (mode == MODE_8);
  endfunction

endpackage

// File: rtl/idct_tbuf_reader.sv
// rtl/idct_tbuf_reader.sv - read counter, transposed address map and column-pass output registers
module idct_tbuf_reader
  import idct_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bank_full,
  input  logic [1:0]        mode_b0,
  input  logic [1:0]        mode_b1,
  input  logic              col_ready,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_done,
  output logic              col_valid,
  output logic [1:0]        col_mode,
  output logic              col_last,
  output logic              block_done
);

  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic              col_valid_q, col_valid_d;
  logic              col_last_q, col_last_d;
  logic [1:0]        col_mode_q, col_mode_d;
  logic              block_done_q, block_done_d;
  logic [1:0]        rd_mode;
  logic              rd_final;

  always_comb begin
    rd_bank_d    = rd_bank_q;
    rd_cnt_d     = rd_cnt_q;
    rd_mode      = rd_bank_q ? mode_b1 : mode_b0;
    rd_final     = (rd_cnt_q == ADDR_W'(blk_last(rd_mode)));
    rd_en        = !rst && bank_full[rd_bank_q] && col_ready;
    rd_done      = rd_en && rd_final;

    // Column-major walk over the row-major block held in the bank
    if (rd_mode == MODE_8) begin
      rd_addr = ADDR_W'({rd_cnt_q[2:0], rd_cnt_q[5:3]});
    end else begin
      rd_addr = ADDR_W'({2'b00, rd_cnt_q[1:0], rd_cnt_q[3:2]});
    end

    col_valid_d  = rd_en;
    col_last_d   = rd_done;
    col_mode_d   = rd_en ? rd_mode : MODE_NONE;
    block_done_d = col_last_q;

    if (rd_en) begin
      if (rd_final) begin
        rd_cnt_d  = '0;
        rd_bank_d = !rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q    <= 1'b0;
      rd_cnt_q     <= '0;
      col_valid_q  <= 1'b0;
      col_last_q   <= 1'b0;
      col_mode_q   <= MODE_NONE;
      block_done_q <= 1'b0;
    end else begin
      rd_bank_q    <= rd_bank_d;
      rd_cnt_q     <= rd_cnt_d;
      col_valid_q  <= col_valid_d;
      col_last_q   <= col_last_d;
      col_mode_q   <= col_mode_d;
      block_done_q <= block_done_d;
    end
  end

  assign rd_bank    = rd_bank_q;
  assign col_valid  = col_valid_q;
  assign col_last   = col_last_q;
  assign col_mode   = col_mode_q;
  assign block_done = block_done_q;

endmodule

// File: rtl/idct_tbuf_sched.sv
// rtl/idct_tbuf_sched.sv - ping-pong transpose buffer scheduler between row and column IDCT passes
module idct_tbuf_sched
  import idct_pkg::*;
#(
  parameter int WIDTH_X = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic              in_last,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              col_ready,
  output logic              col_valid,
  output logic [1:0]        col_mode,
  output logic              col_last,
  output logic              block_done,
  output logic              err_len,
  output logic              err_mode
);

  if (WIDTH_X < 1) begin : g_width_check
    $error("WIDTH_X must be at least 1");
  end

  logic [1:0]        bank_full_q, bank_full_d;
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0][1:0]   wr_mode_q, wr_mode_d;
  logic              err_len_q, err_len_d;
  logic              err_mode_q, err_mode_d;
  logic              accept, blk_start, legal, wr_final;
  logic [1:0]        beat_mode;
  logic              rd_done;

  always_comb begin
    bank_full_d = bank_full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    wr_mode_d   = wr_mode_q;

    in_ready  = !rst && !bank_full_q[wr_bank_q];
    accept    = in_valid && in_ready;
    blk_start = (wr_cnt_q == '0);
    // Mode is only sampled at block start; later beats follow the latched bank mode
    beat_mode = blk_start ? in_mode : wr_mode_q[wr_bank_q];
    legal     = mode_legal(beat_mode);
    wr_final  = (wr_cnt_q == ADDR_W'(blk_last(beat_mode)));
    wr_en     = accept && legal;
    wr_addr   = wr_cnt_q;

    err_mode_d = accept && !legal;
    err_len_d  = wr_en && (in_last != wr_final);

    if (wr_en) begin
      if (blk_start) begin
        wr_mode_d[wr_bank_q] = in_mode;
      end
      if (wr_final) begin
        wr_cnt_d               = '0;
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      end
    end

    // Set needs an empty bank, so a same-cycle clear always targets the other one
    if (rd_done) begin
      bank_full_d[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_full_q <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      wr_mode_q   <= '0;
      err_len_q   <= 1'b0;
      err_mode_q  <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      wr_mode_q   <= wr_mode_d;
      err_len_q   <= err_len_d;
      err_mode_q  <= err_mode_d;
    end
  end

  assign wr_bank  = wr_bank_q;
  assign err_len  = err_len_q;
  assign err_mode = err_mode_q;

  idct_tbuf_reader #(
    .ADDR_W (ADDR_W)
  ) u_reader (
    .clk        (clk),
    .rst        (rst),
    .bank_full  (bank_full_q),
    .mode_b0    (wr_mode_q[0]),
    .mode_b1    (wr_mode_q[1]),
    .col_ready  (col_ready),
    .rd_en      (rd_en),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .col_valid  (col_valid),
    .col_mode   (col_mode),
    .col_last   (col_last),
    .block_done (block_done)
  );

endmodule

// File: tb/tb_idct_tbuf_sched.sv
// tb/tb_idct_tbuf_sched.sv - directed scoreboard bench for idct_tbuf_sched
module tb_idct_tbuf_sched;

  localparam logic [1:0] M4 = 2'b01;
  localparam logic [1:0] M8 = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [1:0] in_mode = 2'b00;
  logic       col_ready = 1'b0;
  logic       in_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic       col_valid, col_last, block_done, err_len, err_mode;
  logic [5:0] wr_addr, rd_addr;
  logic [1:0] col_mode;

  typedef struct {
    logic       bank;
    logic [5:0] addr;
    logic [1:0] mode;
    logic       last;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  rd_exp_t col_q[$];
  rd_exp_t mon_e;

  int vecs = 0;
  int errs = 0;
  logic       m_wbank = 1'b0;
  int         m_wcnt = 0;
  logic [1:0] m_mode = 2'b00;
  int stall_cnt = 0, cyc = 0, cv_count = 0, cv_first = -1, cv_last = -1;
  int errlen_cnt = 0, errmode_cnt = 0, n3 = 0;
  logic found3 = 1'b0;
  logic b0 = 1'b0;
  logic prev_rst = 1'b1, prev_col_last = 1'b0;

  always #5 clk = ~clk;

  idct_tbuf_sched #(.WIDTH_X(16), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_last(in_last),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .col_ready(col_ready), .col_valid(col_valid), .col_mode(col_mode), .col_last(col_last),
    .block_done(block_done), .err_len(err_len), .err_mode(err_mode)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int blk_len(input logic [1:0] mode);
    return (mode == M4) ? 16 : 64;
  endfunction

  // Expected transposed read order: element (row r, col c) sits at r*side+c
  task automatic push_block(input logic bank, input logic [1:0] mode);
    int n;
    int side;
    rd_exp_t e;
    n = blk_len(mode);
    side = (n == 16) ? 4 : 8;
    for (int k = 0; k < n; k++) begin
      e.bank = bank;
      e.addr = 6'((k % side) * side + k / side);
      e.mode = mode;
      e.last = (k == n - 1);
      rd_q.push_back(e);
    end
  endtask

  task automatic beat(input logic [1:0] mode, input logic lst);
    int n = 0;
    logic legal;
    logic exp_len = 1'b0;
    logic exp_mode = 1'b0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_last  = lst;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      stall_cnt++;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      legal = (m_wcnt != 0) || (mode == M4) || (mode == M8);
      chk("wr_en", 32'(wr_en), 32'(legal));
      if (!legal) begin
        exp_mode = 1'b1;
      end else begin
        if (m_wcnt == 0) m_mode = mode;
        chk("wr_addr", 32'(wr_addr), 32'(m_wcnt));
        chk("wr_bank", 32'(wr_bank), 32'(m_wbank));
        exp_len = (lst != (m_wcnt == blk_len(m_mode) - 1));
        if (m_wcnt == blk_len(m_mode) - 1) begin
          push_block(m_wbank, m_mode);
          m_wcnt  = 0;
          m_wbank = ~m_wbank;
        end else begin
          m_wcnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("err_len", 32'(err_len), 32'(exp_len));
    chk("err_mode", 32'(err_mode), 32'(exp_mode));
  endtask

  task automatic send_block(input logic [1:0] mode, input int bad_last);
    int n;
    n = blk_len(mode);
    for (int i = 0; i < n; i++) beat(mode, (i == n - 1) || (i == bad_last));
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((rd_q.size() != 0 || col_q.size() != 0 || col_valid || block_done) && n < 600);
    chk("drain_done", 32'(n < 600), 32'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rd_en) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 32'(rd_en), 32'd0);
      end else begin
        mon_e = rd_q.pop_front();
        chk("rd_addr", 32'(rd_addr), 32'(mon_e.addr));
        chk("rd_bank", 32'(rd_bank), 32'(mon_e.bank));
        col_q.push_back(mon_e);
      end
    end
    if (col_valid) begin
      cv_count++;
      if (cv_first < 0) cv_first = cyc;
      cv_last = cyc;
      if (col_q.size() == 0) begin
        chk("col_unexpected", 32'(col_valid), 32'd0);
      end else begin
        mon_e = col_q.pop_front();
        chk("col_mode", 32'(col_mode), 32'(mon_e.mode));
        chk("col_last", 32'(col_last), 32'(mon_e.last));
      end
    end else begin
      chk("col_idle", 32'({col_mode, col_last}), 32'd0);
    end
    chk("block_done", 32'(block_done), 32'(prev_rst ? 1'b0 : prev_col_last));
    if (err_len) errlen_cnt++;
    if (err_mode) errmode_cnt++;
    prev_rst = rst;
    prev_col_last = col_last;
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wr_rd_en", 32'({wr_en, rd_en}), 32'd0);
    chk("rst_errs", 32'({err_len, err_mode}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_banks", 32'({wr_bank, rd_bank}), 32'd0);
    chk("idle_addrs", 32'({wr_addr, rd_addr}), 32'd0);
    @(posedge clk);
    #1;

    // 1: single 8x8 block, fill-to-read latency
    col_ready = 1'b1;
    send_block(M8, -1);
    @(negedge clk);
    chk("t1_rd_start", 32'(rd_en), 32'd1);
    chk("t1_col_wait", 32'(col_valid), 32'd0);
    @(negedge clk);
    chk("t1_col_start", 32'(col_valid), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // 2: single 4x4 block
    send_block(M4, -1);
    drain();

    // 3: both banks fill with the column pass stalled
    col_ready = 1'b0;
    stall_cnt = 0;
    b0 = m_wbank;
    send_block(M8, -1);
    send_block(M8, -1);
    chk("t3_no_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    chk("t3_full_in_ready", 32'(in_ready), 32'd0);
    chk("t3_full_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk);
    #1;
    col_ready = 1'b1;
    n3 = 0;
    found3 = 1'b0;
    while (!found3 && n3 < 200) begin
      @(negedge clk);
      n3++;
      if (rd_en && rd_bank == b0 && rd_addr == 6'd63) found3 = 1'b1;
    end
    chk("t3_final_read_seen", 32'(found3), 32'd1);
    chk("t3_in_ready_at_final", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("t3_in_ready_rise", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    send_block(M8, -1);
    drain();

    // 4: continuous streaming
    stall_cnt = 0;
    cv_count = 0;
    cv_first = -1;
    cv_last = -1;
    send_block(M8, -1);
    send_block(M8, -1);
    send_block(M8, -1);
    drain();
    chk("t4_no_stall", 32'(stall_cnt), 32'd0);
    chk("t4_cv_count", 32'(cv_count), 32'd192);
    chk("t4_cv_contig", 32'(cv_last - cv_first + 1), 32'd192);

    // 5: in_last mismatch and illegal modes
    errlen_cnt = 0;
    errmode_cnt = 0;
    send_block(M8, 9);
    chk("t5_errlen_once", 32'(errlen_cnt), 32'd1);
    beat(2'b11, 1'b0);
    beat(2'b00, 1'b0);
    send_block(M4, -1);
    chk("t5_errmode_count", 32'(errmode_cnt), 32'd2);
    drain();

    // 6: reset mid-read with the other bank full
    col_ready = 1'b0;
    send_block(M8, -1);
    send_block(M8, -1);
    col_ready = 1'b1;
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_rd_en", 32'(rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd_q.delete();
    m_wcnt = 0;
    m_wbank = 1'b0;
    @(negedge clk);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_outputs_zero", 32'({wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, col_valid,
                                col_mode, col_last, block_done, err_len, err_mode}), 32'd0);
    @(posedge clk);
    #1;
    send_block(M8, -1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
